mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/otter_arb_pkg.sv | 13 +
 rtl/mux_2t1_nb.sv | 13 +
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int TMO_DEFAULT = 15;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/mux_2t1_nb.sv
// n-bit two-to-one multiplexer.
module mux_2t1_nb #(
  parameter int n = 32
) (
  input  logic         i_sel,
  input  logic [n-1:0] i_d0,
  input  logic [n-1:0] i_d1,
  output logic [n-1:0] o_d
);

  assign o_d = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port with a BUSY-cycle timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (REQ1 wins).
module mem_port_arbiter
  import otter_arb_pkg::*;
#(
  parameter int n   = 32,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ0,
  input  logic [n-1:0] ADDR0,
  input  logic         REQ1,
  input  logic [n-1:0] ADDR1,
  input  logic         MEM_RDY,
  output logic         SEL,
  output logic         MEM_VALID,
  output logic [n-1:0] MEM_ADDR,
  output logic         ACK0,
  output logic         ACK1,
  output logic         ERR
);

  // Counter holds the number of BUSY cycles already completed.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

  arb_state_t       r_state;
  logic             r_sel;
  logic [n-1:0]     r_mem_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_err;

  arb_state_t       w_state_nxt;
  logic             w_sel_nxt;
  logic [n-1:0]     w_addr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ack0_nxt;
  logic             w_ack1_nxt;
  logic             w_err_nxt;
  logic             w_win;
  logic             w_tmo;
  logic [n-1:0]     w_mux_out;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;
  logic w_last_nxt;

  assign w_win = (REQ0 & REQ1) ? ~r_last : REQ1;
`else
  assign w_win = REQ1;
`endif

  mux_2t1_nb #(
    .n (n)
  ) u_addr_mux (
    .i_sel (w_win),
    .i_d0  (ADDR0),
    .i_d1  (ADDR1),
    .o_d   (w_mux_out)
  );

  assign w_tmo = (r_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_mem_addr;
    w_cnt_nxt   = r_cnt;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_last_nxt  = r_last;
`endif
    case (r_state)
      IDLE: begin
        if (REQ0 | REQ1) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = w_win;
          w_addr_nxt  = w_mux_out;
          w_cnt_nxt   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w_last_nxt  = w_win;
`endif
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // A completion on the timeout cycle still counts as a clean completion.
        if (MEM_RDY || w_tmo) begin
          w_state_nxt = RESP;
          w_ack0_nxt  = ~r_sel;
          w_ack1_nxt  = r_sel;
          w_err_nxt   = ~MEM_RDY;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_err      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last     <= 1'b1;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_mem_addr <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_err      <= w_err_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last     <= w_last_nxt;
`endif
    end
  end

  assign SEL       = r_sel;
  assign MEM_VALID = (r_state == BUSY);
  assign MEM_ADDR  = r_mem_addr;
  assign ACK0      = r_ack0;
  assign ACK1      = r_ack1;
  assign ERR       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expectations queued at request launch, checked at ACK.
module tb_mem_port_arbiter;

  localparam int N   = 32;
  localparam int TMO = 15;

  logic         CLK = 1'b0;
  logic         RST;
  logic         REQ0;
  logic [N-1:0] ADDR0;
  logic         REQ1;
  logic [N-1:0] ADDR1;
  logic         MEM_RDY;
  logic         SEL;
  logic         MEM_VALID;
  logic [N-1:0] MEM_ADDR;
  logic         ACK0;
  logic         ACK1;
  logic         ERR;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        err;
    int          busy;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  logic [2:0] tie_order;

  mem_port_arbiter #(
    .n   (N),
    .TMO (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ0      (REQ0),
    .ADDR0     (ADDR0),
    .REQ1      (REQ1),
    .ADDR1     (ADDR1),
    .MEM_RDY   (MEM_RDY),
    .SEL       (SEL),
    .MEM_VALID (MEM_VALID),
    .MEM_ADDR  (MEM_ADDR),
    .ACK0      (ACK0),
    .ACK1      (ACK1),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge with the arbiter in IDLE.
  task automatic run_txn(input logic q0, input logic q1, input logic [31:0] a0,
                         input logic [31:0] a1, input int rdy_at, input logic exp_sel,
                         input logic hold, input logic perturb);
    exp_t e;
    exp_t got;
    int   k;
    bit   done;
    e.sel  = exp_sel;
    e.addr = exp_sel ? a1 : a0;
    e.err  = !(rdy_at > 0 && rdy_at <= TMO);
    e.busy = e.err ? TMO : rdy_at;
    sb_q.push_back(e);
    REQ0 = q0; REQ1 = q1; ADDR0 = a0; ADDR1 = a1;
    @(posedge CLK); @(negedge CLK);
    chk("busy_valid", 32'(MEM_VALID), 32'd1);
    chk("busy_sel", 32'(SEL), 32'(exp_sel));
    chk("busy_addr", MEM_ADDR, e.addr);
    k = 1;
    done = 0;
    while (!done && k <= TMO + 4) begin
      MEM_RDY = (k == rdy_at);
      if (perturb) begin
        ADDR1 = ~ADDR1;
        if (k == 1) begin
          REQ1 = 1'b0; REQ0 = 1'b1; ADDR0 = ~a0;
        end
      end
      @(posedge CLK); @(negedge CLK);
      if (ACK0 || ACK1) begin
        done = 1;
      end else begin
        k++;
        chk("stable_sel", 32'(SEL), 32'(exp_sel));
        chk("stable_addr", MEM_ADDR, e.addr);
      end
    end
    if (!done) chk("ack_seen", 32'd0, 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      if (done) begin
        chk("ack0", 32'(ACK0), 32'(!got.sel));
        chk("ack1", 32'(ACK1), 32'(got.sel));
        chk("err", 32'(ERR), 32'(got.err));
        chk("resp_valid", 32'(MEM_VALID), 32'd0);
        chk("resp_sel", 32'(SEL), 32'(got.sel));
        chk("resp_addr", MEM_ADDR, got.addr);
        chk("busy_cycles", 32'(k), 32'(got.busy));
      end
      $display("txn sel=%0d addr=0x%0h err=%0d busy=%0d", SEL, MEM_ADDR, ERR, k);
    end
    MEM_RDY = 1'b0;
    if (!hold) begin
      REQ0 = 1'b0; REQ1 = 1'b0;
    end
    @(posedge CLK); @(negedge CLK);
    chk("ack_pulse", 32'({ACK0, ACK1, ERR}), 32'd0);
    chk("idle_valid", 32'(MEM_VALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_order = 3'b010;
`else
    tie_order = 3'b111;
`endif
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; ADDR0 = '0; ADDR1 = '0; MEM_RDY = 1'b0;
    @(negedge CLK);
    chk("rst_sel", 32'(SEL), 32'd0);
    chk("rst_valid", 32'(MEM_VALID), 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    chk("rst_acks", 32'({ACK0, ACK1, ERR}), 32'd0);
    RST = 1'b0;

    // Tie held across three transactions straight out of reset.
    for (int i = 0; i < 3; i++)
      run_txn(1'b1, 1'b1, 32'h200, 32'h300, 1, tie_order[i], (i < 2), 1'b0);

    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 2, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0, 32'hABC, 0, 1'b1, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h7F0, 32'h0, TMO, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h7F4, 32'h0, TMO - 1, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h0, 32'h5A5, 4, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge CLK);
    chk("idle_hold_sel", 32'(SEL), 32'd1);
    chk("idle_hold_addr", MEM_ADDR, 32'h5A5);
    chk("idle_hold_valid", 32'(MEM_VALID), 32'd0);

    // Reset pulse between clock edges while an access is in flight.
    REQ0 = 1'b1; ADDR0 = 32'h44;
    @(posedge CLK); @(negedge CLK);
    chk("pre_rst_valid", 32'(MEM_VALID), 32'd1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_sel", 32'(SEL), 32'd0);
    chk("arst_valid", 32'(MEM_VALID), 32'd0);
    chk("arst_addr", MEM_ADDR, 32'd0);
    chk("arst_acks", 32'({ACK0, ACK1, ERR}), 32'd0);
    RST = 1'b0; REQ0 = 1'b0; MEM_RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("no_ack_after_rst", 32'({ACK0, ACK1}), 32'd0);
      chk("no_valid_after_rst", 32'(MEM_VALID), 32'd0);
    end
    MEM_RDY = 1'b0;
    run_txn(1'b1, 1'b0, 32'h88, 32'h0, 1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
